branch_redirect_unit: RTL

// - Downstream of the integer ALUs. Collects per-ALU branch results and picks the oldest mispredict by ROB age.
// - Holds that mispredict as a pending redirect to the frontend under a valid/ready handshake.
// - Pulses a backend squash so instructions younger than the branch are killed; counts mispredicts.

---
 rtl/branch_redirect_unit_pkg.sv | 56 +++++
 rtl/branch_redirect_unit_oldest_sel.sv | 49 ++++
 rtl/branch_redirect_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/branch_redirect_unit_pkg.sv
// Shared types for the branch redirect unit: branch results, redirect payload and ROB age compare.
package branch_redirect_unit_pkg;

  localparam int unsigned ROB_IDX_W = 7;
  localparam int unsigned FSQ_IDX_W = 5;
  localparam int unsigned PRED_W    = 3;
  localparam int unsigned VADDR_W   = 32;
  localparam int unsigned CNT_W     = 32;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_COND,
    BR_DIRECT,
    BR_INDIRECT
  } BranchType;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } RasType;

  typedef struct packed {
    logic               direction;
    logic               error;
    logic [VADDR_W-1:0] target;
    BranchType          br_type;
    RasType             ras_type;
  } BranchUnitRes;

  typedef struct packed {
    logic [FSQ_IDX_W-1:0] fsq_idx;
    logic [PRED_W-1:0]    offset;
    logic [VADDR_W-1:0]   target;
    logic                 direction;
    BranchType            br_type;
    RasType               ras_type;
    logic [ROB_IDX_W-1:0] rob_idx;
  } RedirectReq;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } bru_state_e;

  // True when a is older than b; the MSB is the ROB wrap flag.
  function automatic logic rob_older(input logic [ROB_IDX_W-1:0] a,
                                     input logic [ROB_IDX_W-1:0] b);
    if (a[ROB_IDX_W-1] == b[ROB_IDX_W-1]) begin
      return a[ROB_IDX_W-2:0] < b[ROB_IDX_W-2:0];
    end
    return a[ROB_IDX_W-2:0] > b[ROB_IDX_W-2:0];
  endfunction

endpackage

// File: rtl/branch_redirect_unit_oldest_sel.sv
// Oldest-by-ROB-age select across ALU lanes. Log-depth tree compares only ages and
// lane numbers; the winning payload is muxed once at the root.
module redirect_oldest_sel
  import branch_redirect_unit_pkg::*;
#(
  parameter int unsigned ALU_NUM = 4
) (
  input  logic                     valid_i [ALU_NUM],
  input  RedirectReq               req_i   [ALU_NUM],
  output logic                     valid_o,
  output RedirectReq               req_o
);

  localparam int unsigned LVL    = $clog2(ALU_NUM);
  localparam int unsigned LEAVES = 1 << LVL;
  localparam int unsigned LANE_W = (LVL > 0) ? LVL : 1;

  logic                 node_v    [LEAVES];
  logic [ROB_IDX_W-1:0] node_rob  [LEAVES];
  logic [LANE_W-1:0]    node_lane [LEAVES];
  logic                 take_r;

  // In-place pairwise reduction; on equal age the left (lower) lane is kept.
  always_comb begin
    take_r = 1'b0;
    for (int i = 0; i < int'(LEAVES); i++) begin
      node_v[i]    = 1'b0;
      node_rob[i]  = '0;
      node_lane[i] = LANE_W'(i);
      if (i < int'(ALU_NUM)) begin
        node_v[i]   = valid_i[i];
        node_rob[i] = req_i[i].rob_idx;
      end
    end
    for (int l = 0; l < int'(LVL); l++) begin
      for (int k = 0; k < int'(LEAVES >> (l + 1)); k++) begin
        take_r = node_v[2*k+1] &&
                 (!node_v[2*k] || rob_older(node_rob[2*k+1], node_rob[2*k]));
        node_v[k]    = node_v[2*k] | node_v[2*k+1];
        node_rob[k]  = take_r ? node_rob[2*k+1]  : node_rob[2*k];
        node_lane[k] = take_r ? node_lane[2*k+1] : node_lane[2*k];
      end
    end
  end

  assign valid_o = node_v[0];
  assign req_o   = req_i[node_lane[0]];

endmodule

// File: rtl/branch_redirect_unit.sv
// Picks the oldest mispredicted branch across ALU lanes, holds it as a frontend redirect,
// pulses a backend squash and counts accepted redirects.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int unsigned ALU_NUM = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ALU_NUM-1:0]                  br_en,
  input  BranchUnitRes [ALU_NUM-1:0]          br_res,
  input  logic [ALU_NUM-1:0][ROB_IDX_W-1:0]   br_rob_idx,
  input  logic [ALU_NUM-1:0][FSQ_IDX_W-1:0]   br_fsq_idx,
  input  logic [ALU_NUM-1:0][PRED_W-1:0]      br_offset,
  input  logic                                flush,
  output logic                                redirect_valid,
  input  logic                                redirect_ready,
  output RedirectReq                          redirect,
  output logic                                squash_valid,
  output logic [ROB_IDX_W-1:0]                squash_rob_idx,
  output logic [CNT_W-1:0]                    mispred_cnt
);

  bru_state_e           state_q;
  RedirectReq           req_q;
  logic                 squash_q;
  logic [ROB_IDX_W-1:0] squash_idx_q;
  logic                 fence_valid_q;
  logic [ROB_IDX_W-1:0] fence_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  logic                 lane_v   [ALU_NUM];
  RedirectReq           lane_req [ALU_NUM];
  logic                 sel_v;
  RedirectReq           sel_req;
  logic                 cand;
  logic                 cand_older;

  // Per-lane redirect payload; only lanes reporting a direction/target error compete.
  always_comb begin
    for (int i = 0; i < int'(ALU_NUM); i++) begin
      lane_v[i]             = br_en[i] & br_res[i].error;
      lane_req[i].fsq_idx   = br_fsq_idx[i];
      lane_req[i].offset    = br_offset[i];
      lane_req[i].target    = br_res[i].target;
      lane_req[i].direction = br_res[i].direction;
      lane_req[i].br_type   = br_res[i].br_type;
      lane_req[i].ras_type  = br_res[i].ras_type;
      lane_req[i].rob_idx   = br_rob_idx[i];
    end
  end

  redirect_oldest_sel #(
    .ALU_NUM (ALU_NUM)
  ) u_sel (
    .valid_i (lane_v),
    .req_i   (lane_req),
    .valid_o (sel_v),
    .req_o   (sel_req)
  );

  // Results younger than the last accepted redirect belong to already-killed instructions.
  assign cand       = sel_v && !(fence_valid_q && rob_older(fence_q, sel_req.rob_idx));
  assign cand_older = cand && rob_older(sel_req.rob_idx, req_q.rob_idx);
  assign cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      req_q         <= '0;
      squash_q      <= 1'b0;
      squash_idx_q  <= '0;
      fence_valid_q <= 1'b0;
      fence_q       <= '0;
      cnt_q         <= '0;
    end else begin
      squash_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            fence_valid_q <= 1'b0;
          end else if (cand) begin
            req_q        <= sel_req;
            squash_q     <= 1'b1;
            squash_idx_q <= sel_req.rob_idx;
            state_q      <= S_PEND;
          end
        end
        S_PEND: begin
          if (flush) begin
            fence_valid_q <= 1'b0;
            state_q       <= S_IDLE;
          end else if (cand_older) begin
            req_q        <= sel_req;
            squash_q     <= 1'b1;
            squash_idx_q <= sel_req.rob_idx;
            if (redirect_ready) begin
              cnt_q         <= cnt_d;
              fence_q       <= req_q.rob_idx;
              fence_valid_q <= 1'b1;
            end
          end else if (redirect_ready) begin
            cnt_q         <= cnt_d;
            fence_q       <= req_q.rob_idx;
            fence_valid_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign redirect_valid = (state_q == S_PEND);
  assign redirect       = req_q;
  assign squash_valid   = squash_q;
  assign squash_rob_idx = squash_idx_q;
  assign mispred_cnt    = cnt_q;

endmodule
